// File: rtl/instmem_loadable.sv
// Writable instruction memory with a valid/ready load port and 1-cycle fetch.
// Optional per-word even parity when INSTMEM_PARITY_EN is defined.
module instmem_loadable #(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter int CW = AW + 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [31:0]   a,
  input  logic          fetch_req,
  output logic [DW-1:0] inst,
  output logic          inst_valid,
  output logic          fetch_stall,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_done,
  output logic [CW-1:0] ld_count,
  output logic          inst_perr
);

  localparam int DEPTH = 1 << AW;
`ifdef INSTMEM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [MW-1:0]   mem [DEPTH];
  logic [AW-1:0]   ptr;
  logic [AW-1:0]   ridx;
  logic [MW-1:0]   wword;
  logic [MW-1:0]   rword;
  logic            hs;
  logic            fe;
  logic            unused_abits;

  assign ridx         = a[AW+1:2];
  assign unused_abits = ^{a[31:AW+2], a[1:0]};
  assign ld_ready     = (state == LOAD);
  assign hs           = ld_valid & ld_ready;
  assign fe           = fetch_req & (state == IDLE);
  assign fetch_stall  = fetch_req & (state == LOAD);
  assign rword        = mem[ridx];

`ifdef INSTMEM_PARITY_EN
  assign wword = {^ld_data, ld_data};
`else
  assign wword = ld_data;
`endif

  // state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_n;
  end

  // next state: start a burst, end it on the last handshake
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (ld_start)       state_n = LOAD;
      LOAD:    if (hs && ld_last)  state_n = IDLE;
      default:                     state_n = IDLE;
    endcase
  end

  // storage write; contents survive reset
  always_ff @(posedge clk) begin
    if (hs) mem[ptr] <= wword;
  end

  // write pointer, burst word count and done pulse
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ptr      <= '0;
      ld_count <= '0;
      ld_done  <= 1'b0;
    end else begin
      ld_done <= hs & ld_last;
      if ((state == IDLE) && ld_start) begin
        ptr      <= ld_base;
        ld_count <= '0;
      end else if (hs) begin
        ptr <= ptr + AW'(1);
        if (ld_count != '1) ld_count <= ld_count + CW'(1);
      end
    end
  end

  // registered fetch; inst holds when no fetch is accepted
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      inst       <= '0;
      inst_valid <= 1'b0;
    end else begin
      inst_valid <= fe;
      if (fe) inst <= rword[DW-1:0];
    end
  end

`ifdef INSTMEM_PARITY_EN
  // parity check of the fetched entry, aligned with inst_valid
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) inst_perr <= 1'b0;
    else       inst_perr <= fe & (^rword);
  end
`else
  assign inst_perr = 1'b0;
`endif

endmodule

// File: tb/tb_instmem_loadable.sv
// Randomised scoreboard bench for instmem_loadable.
// Reference memory is a plain array updated per accepted load word.
module tb_instmem_loadable;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 0;
  logic          clrn;
  logic [31:0]   a;
  logic          fetch_req;
  logic [DW-1:0] inst;
  logic          inst_valid;
  logic          fetch_stall;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_done;
  logic [CW-1:0] ld_count;
  logic          inst_perr;

  instmem_loadable #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .clrn(clrn), .a(a), .fetch_req(fetch_req),
    .inst(inst), .inst_valid(inst_valid), .fetch_stall(fetch_stall),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .ld_done(ld_done), .ld_count(ld_count), .inst_perr(inst_perr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        p;
    int          c;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mm [DEPTH];
  bit          wr [DEPTH];
  logic [31:0] wq[$];
  logic [31:0] held;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(int idx);
    logic [31:0] r;
    r = $urandom;
    r[AW+1:2] = idx[AW-1:0];
    return r;
  endfunction

  function automatic void push(logic [31:0] d, logic p);
    exp_t e;
    e.d = d;
    e.p = p;
    e.c = cyc + 1;
    sb.push_back(e);
  endfunction

  // monitor: scheduled results must appear exactly on their cycle
  always @(negedge clk) begin
    exp_t e;
    if (!clrn) begin
      held = '0;
    end else if (sb.size() > 0 && sb[0].c == cyc) begin
      e = sb.pop_front();
      chk("fetch_valid", inst_valid, 1);
      chk("fetch_data", inst, e.d);
      chk("fetch_perr", inst_perr, e.p);
      held = e.d;
    end else begin
      chk("no_valid", inst_valid, 0);
      chk("perr_quiet", inst_perr, 0);
      chk("inst_hold", inst, held);
    end
  end

  task automatic fetch(logic [31:0] addr);
    fetch_req = 1;
    a = addr;
    push(mm[addr[AW+1:2]], 1'b0);
    step();
    fetch_req = 0;
  endtask

  task automatic load(int base, int n, bit bub, bit probe, int restart,
                      int abort_after, bit simf, logic [31:0] fa);
    int ptr;
    int hs;
    bit did_rs;
    bit do_bub;
    ptr = base;
    hs = 0;
    did_rs = 0;
    ld_start = 1;
    ld_base = base[AW-1:0];
    if (simf) begin
      fetch_req = 1;
      a = fa;
      push(mm[fa[AW+1:2]], 1'b0);
    end
    #1 chk("ready_before_start", ld_ready, 0);
    step();
    ld_start = 0;
    chk("ready_on", ld_ready, 1);
    chk("count_clear", ld_count, 0);
    if (simf) begin
      chk("stall_after_sim", fetch_stall, 1);
      fetch_req = 0;
    end
    while (hs < n) begin
      do_bub = bub && ($urandom_range(0, 1) == 1);
      if (hs == restart && !did_rs) begin
        do_bub = 1;
        did_rs = 1;
      end
      if (do_bub) begin
        ld_valid = 0;
        ld_data = $urandom;
        ld_last = $urandom_range(0, 1);
        if (did_rs && hs == restart) begin
          ld_start = 1;
          ld_base = AW'(ptr + 7);
        end
        if (probe) begin
          fetch_req = 1;
          a = $urandom;
        end
        #1 if (probe) chk("stall_bubble", fetch_stall, 1);
        step();
        ld_start = 0;
        ld_last = 0;
        fetch_req = 0;
        chk("count_bubble", ld_count, hs);
      end else begin
        ld_valid = 1;
        ld_data = wq[hs];
        ld_last = (hs == n - 1);
        if (probe) begin
          fetch_req = 1;
          a = $urandom;
        end
        #1 if (probe) chk("stall_hs", fetch_stall, 1);
        step();
        mm[ptr % DEPTH] = wq[hs];
        wr[ptr % DEPTH] = 1;
        ptr++;
        hs++;
        ld_valid = 0;
        ld_last = 0;
        fetch_req = 0;
        if (hs == n) begin
          chk("done_pulse", ld_done, 1);
          chk("count_final", ld_count, n);
          chk("ready_off", ld_ready, 0);
        end else begin
          chk("done_early", ld_done, 0);
          chk("count_mid", ld_count, hs);
        end
        if (hs == abort_after) begin
          clrn = 0;
          #1;
          chk("abort_ready", ld_ready, 0);
          chk("abort_count", ld_count, 0);
          chk("abort_done", ld_done, 0);
          step();
          step();
          clrn = 1;
          for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_no_done", ld_done, 0);
            chk("abort_idle", ld_ready, 0);
          end
          return;
        end
      end
    end
    step();
    chk("done_once", ld_done, 0);
  endtask

  initial begin
    int n;
    int idx;
    clrn = 0;
    fetch_req = 1;
    a = 0;
    ld_start = 0;
    ld_base = 0;
    ld_valid = 0;
    ld_data = 0;
    ld_last = 0;
    held = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mm[i] = 'x;
      wr[i] = 0;
    end
    step();
    step();
    chk("rst_inst", inst, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_count", ld_count, 0);
    chk("rst_done", ld_done, 0);
    chk("rst_perr", inst_perr, 0);
    fetch_req = 0;
    clrn = 1;
    step();
    chk("idle_stall", fetch_stall, 0);

    wq = '{32'h00400493, 32'h0104F457, 32'h04800293, 32'h0202E107};
    load(0, 4, 0, 0, -1, -1, 0, 0);
    fetch(32'h0000000C);
    fetch(32'h00000000);
    fetch(32'hFFFFFF05);

    wq = '{32'hAAAA5555, 32'h12345678};
    load(DEPTH - 1, 2, 0, 0, -1, -1, 0, 0);
    fetch(4 * (DEPTH - 1));
    fetch(32'h00000000);

    wq.delete();
    for (int i = 0; i < 6; i++) wq.push_back($urandom);
    load(10, 6, 1, 1, 3, -1, 0, 0);
    for (int i = 10; i < 16; i++) fetch(mk(i));

    wq = '{32'h11111111, 32'h22222222, 32'h33333333};
    load(20, 3, 0, 0, -1, -1, 1, 32'h00000008);
    for (int i = 20; i < 23; i++) fetch(mk(i));

    wq = '{32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004};
    load(30, 4, 0, 0, -1, 2, 0, 0);
    fetch(mk(30));
    fetch(mk(31));

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 9);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      load($urandom_range(0, DEPTH - 1), n, 1, $urandom_range(0, 1),
           $urandom_range(0, n), -1, 0, 0);
      for (int f = 0; f < 8; f++) begin
        idx = $urandom_range(0, DEPTH - 1);
        while (!wr[idx]) idx = (idx + 1) % DEPTH;
        fetch(mk(idx));
        if ($urandom_range(0, 2) == 0) step();
      end
    end

`ifdef INSTMEM_PARITY_EN
    dut.mem[0][3] = ~dut.mem[0][3];
    fetch_req = 1;
    a = 0;
    push(mm[0] ^ 32'h8, 1'b1);
    step();
    fetch_req = 0;
    fetch(32'h00000004);
`endif

    step();
    step();
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
